// File: rtl/hard_mem_gen_pkg.sv
// Shared types and helpers for the generic hard-memory wrappers.
package hard_mem_gen_pkg;

    typedef enum logic {eInit = 1'b0, eReady = 1'b1} hard_mem_init_state_e;

    function automatic int mask_width(input int width, input int gran);
        return width / gran;
    endfunction

endpackage

// File: rtl/hard_mem_1rw_gen_array.sv
// Bare 1RW synchronous array with a per-bit write enable and a registered read port.
// This is the block that gets swapped for the hardened macro.
module hard_mem_1rw_gen_array #(
    parameter int width_p       = 64,
    parameter int els_p         = 512,
    parameter int addr_width_lp = $clog2(els_p)
) (
    input  logic                     clk_i,
    input  logic                     v_i,
    input  logic                     w_i,
    input  logic [addr_width_lp-1:0] addr_i,
    input  logic [width_p-1:0]       data_i,
    input  logic [width_p-1:0]       w_mask_i,
    output logic [width_p-1:0]       data_o
);

    logic [width_p-1:0] mem_r [els_p];

    // Out-of-range writes are dropped; out-of-range reads return whatever the index yields.
    always_ff @(posedge clk_i) begin
        if (v_i) begin
            if (w_i) begin
                if (int'(addr_i) < els_p)
                    mem_r[addr_i] <= (mem_r[addr_i] & ~w_mask_i) | (data_i & w_mask_i);
            end else begin
                data_o <= mem_r[addr_i];
            end
        end
    end

endmodule

// File: rtl/hard_mem_1rw_mask_init_wrapper.sv
// 1RW memory wrapper: valid/ready request port, held read response (v_o/yumi_i),
// granular write mask and an optional zero-fill sweep after reset.
module hard_mem_1rw_mask_init_wrapper
    import hard_mem_gen_pkg::*;
#(
    parameter int width_p     = 64,
    parameter int els_p       = 512,
    parameter int mask_gran_p = 8,
    parameter int zero_init_p = 1,
    localparam int addr_width_lp = $clog2(els_p),
    localparam int mask_width_lp = mask_width(width_p, mask_gran_p)
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     v_i,
    output logic                     ready_o,
    input  logic                     w_i,
    input  logic [addr_width_lp-1:0] addr_i,
    input  logic [width_p-1:0]       data_i,
    input  logic [mask_width_lp-1:0] w_mask_i,
    output logic                     v_o,
    output logic [width_p-1:0]       data_o,
    input  logic                     yumi_i
);

    if ((width_p % mask_gran_p) != 0) begin : g_bad_gran
        $error("width_p must be a multiple of mask_gran_p");
    end
    if (els_p < 2) begin : g_bad_els
        $error("els_p must be at least 2");
    end

    localparam logic [addr_width_lp-1:0] last_addr_lp = addr_width_lp'(els_p - 1);

    hard_mem_init_state_e     state_r, state_n;
    logic [addr_width_lp-1:0] sweep_cnt_r;
    logic                     sweep_v;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r     <= (zero_init_p != 0) ? eInit : eReady;
            sweep_cnt_r <= '0;
        end else begin
            state_r <= state_n;
            if (sweep_v)
                sweep_cnt_r <= sweep_cnt_r + addr_width_lp'(1);
        end
    end

    always_comb begin
        state_n = state_r;
        if (state_r == eInit && sweep_cnt_r == last_addr_lp)
            state_n = eReady;
    end

    // A pending, unconsumed response blocks new requests; yumi_i frees the slot in the same cycle.
    always_comb begin
        sweep_v = (state_r == eInit);
        ready_o = (state_r == eReady) & ~(v_o & ~yumi_i);
    end

    logic [width_p-1:0] bit_mask;
    for (genvar k = 0; k < mask_width_lp; k++) begin : g_mask
        assign bit_mask[k*mask_gran_p +: mask_gran_p] = {mask_gran_p{w_mask_i[k]}};
    end

    logic                     req_acc;
    logic                     rd_acc;
    logic                     arr_v;
    logic                     arr_w;
    logic [addr_width_lp-1:0] arr_addr;
    logic [width_p-1:0]       arr_data;
    logic [width_p-1:0]       arr_mask;
    logic [width_p-1:0]       arr_dout;

    always_comb begin
        req_acc  = v_i & ready_o;
        rd_acc   = req_acc & ~w_i;
        arr_v    = sweep_v | req_acc;
        arr_w    = sweep_v | w_i;
        arr_addr = sweep_v ? sweep_cnt_r : addr_i;
        arr_data = sweep_v ? '0 : data_i;
        arr_mask = sweep_v ? '1 : bit_mask;
    end

    hard_mem_1rw_gen_array #(
        .width_p      (width_p),
        .els_p        (els_p),
        .addr_width_lp(addr_width_lp)
    ) mem (
        .clk_i   (clk_i),
        .v_i     (arr_v),
        .w_i     (arr_w),
        .addr_i  (arr_addr),
        .data_i  (arr_data),
        .w_mask_i(arr_mask),
        .data_o  (arr_dout)
    );

    // ---- response stage: array port is valid for one cycle, hold register afterwards ----
    logic               rd_fresh_p1;
    logic [width_p-1:0] data_hold_p1;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            v_o          <= 1'b0;
            rd_fresh_p1  <= 1'b0;
            data_hold_p1 <= '0;
        end else begin
            v_o         <= rd_acc | (v_o & ~yumi_i);
            rd_fresh_p1 <= rd_acc;
            if (rd_fresh_p1)
                data_hold_p1 <= arr_dout;
        end
    end

    assign data_o = rd_fresh_p1 ? arr_dout : data_hold_p1;

    always_ff @(posedge clk_i) begin
        if (reset_n_i && req_acc)
            assert (int'(addr_i) < els_p)
            else $error("hard_mem wrapper: address %0d beyond els_p", addr_i);
    end

endmodule
